descrambler_ctrl: RTL



---
 rtl/descrambler_ctrl_pkg.sv | 15 +
 rtl/descrambler_ctrl_frame_phase.sv | 33 +++
 rtl/descrambler_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/descrambler_ctrl_pkg.sv
// Shared types and sizing helpers for the lpGBT descrambler sequencing controller.
package descrambler_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ALIGN, FLUSH, RUN} ctrlState;

  localparam int DESCR_WIDTH       = 36;
  localparam int CLK_PER_FRAME_DEF = 8;
  localparam int ENABLE_PHASE_DEF  = 3;

  // Bits needed to hold any value in 0..maxVal.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/descrambler_ctrl_frame_phase.sv
// Frame phase counter: tracks clock position within a frame and flags misplaced frame syncs.
module frame_phase_counter
  import descrambler_ctrl_pkg::*;
#(
  parameter int CLK_PER_FRAME = CLK_PER_FRAME_DEF,
  localparam int CNT_W = cntWidth(CLK_PER_FRAME - 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             hold,
  input  logic             frameSync,
  output logic [CNT_W-1:0] cntNext,
  output logic             misplaced
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_FRAME - 1);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    cntNext = cnt + 1'b1;
    if (hold || frameSync || cnt == LAST) cntNext = '0;
  end

  // A sync is only legitimate on the last clock of the frame.
  assign misplaced = frameSync && (cnt != LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cntNext;
  end

endmodule

// File: rtl/descrambler_ctrl.sv
// Descrambler sequencer: frame-rate enable strobe, frame-aligned bypass, flush masking and lock/error status.
// state | meaning
// IDLE  | controller disabled, phase counter held at 0
// ALIGN | waiting for first frame sync, no enables issued
// FLUSH | enables issued, history register refilling, output masked
// RUN   | locked, output valid the cycle after each enable
module descrambler_ctrl
  import descrambler_ctrl_pkg::*;
#(
  parameter int CLK_PER_FRAME = CLK_PER_FRAME_DEF,
  parameter int ENABLE_PHASE  = ENABLE_PHASE_DEF,
  parameter int FLUSH_WORDS   = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cfg_enable_i,
  input  logic                 cfg_bypass_i,
  input  logic                 frame_sync_i,
  output logic                 descr_enable_o,
  output logic                 descr_bypass_o,
  output logic                 data_valid_o,
  output logic                 locked_o,
  output logic                 phase_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int CNT_W   = cntWidth(CLK_PER_FRAME - 1);
  localparam int FLUSH_W = cntWidth(FLUSH_WORDS);
  localparam logic [CNT_W-1:0]   ENABLE_CNT = CNT_W'(ENABLE_PHASE);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_WORDS);

  ctrlState           state, stateNext;
  logic [FLUSH_W-1:0] flushCnt, flushNext;
  logic [CNT_W-1:0]   cntNext;
  logic               misplaced, framing, phaseErr, bypassFall, restart;

  frame_phase_counter #(.CLK_PER_FRAME(CLK_PER_FRAME)) uPhase (
    .clock     (clock),
    .reset_n   (reset_n),
    .hold      (state == IDLE),
    .frameSync (frame_sync_i),
    .cntNext   (cntNext),
    .misplaced (misplaced)
  );

  assign framing    = (state == FLUSH) || (state == RUN);
  assign phaseErr   = misplaced && framing;
  // History register was zeroed while bypassed, so leaving bypass needs a refill.
  assign bypassFall = descr_enable_o && descr_bypass_o && !cfg_bypass_i;
  assign restart    = phaseErr || (bypassFall && framing);

  always_comb begin
    stateNext = state;
    flushNext = flushCnt;
    if (!cfg_enable_i) begin
      stateNext = IDLE;
      flushNext = '0;
    end else begin
      case (state)
        IDLE: stateNext = ALIGN;
        ALIGN: if (frame_sync_i) begin
          stateNext = FLUSH;
          flushNext = FLUSH_LOAD;
        end
        FLUSH: if (restart) begin
          flushNext = FLUSH_LOAD;
        end else if (descr_enable_o) begin
          if (flushCnt == FLUSH_W'(1)) begin
            stateNext = RUN;
            flushNext = '0;
          end else begin
            flushNext = flushCnt - 1'b1;
          end
        end
        RUN: if (restart) begin
          stateNext = FLUSH;
          flushNext = FLUSH_LOAD;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      flushCnt       <= '0;
      descr_enable_o <= 1'b0;
      descr_bypass_o <= 1'b1;
      data_valid_o   <= 1'b0;
      locked_o       <= 1'b0;
      phase_err_o    <= 1'b0;
      err_cnt_o      <= '0;
    end else begin
      state          <= stateNext;
      flushCnt       <= flushNext;
      descr_enable_o <= ((stateNext == FLUSH) || (stateNext == RUN)) && (cntNext == ENABLE_CNT);
      data_valid_o   <= descr_enable_o && (state == RUN) && cfg_enable_i;
      locked_o       <= (stateNext == RUN);
      phase_err_o    <= phaseErr;
      if (phaseErr && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + 1'b1;
      if ((state == IDLE) || (state == ALIGN) || descr_enable_o) descr_bypass_o <= cfg_bypass_i;
    end
  end

endmodule
